// File: rtl/mat_key_scanner.sv
// Matrix-keypad scanner: column drive, per-frame debounce and a key-event FIFO.
// Define MAT_KEY_RELEASE_EVT_EN to queue release events as well as presses.
module mat_key_scanner #(
   parameter int N_ROWS     = 4,
   parameter int N_COLS     = 4,
   parameter int SCAN_DIV   = 16,
   parameter int DEBOUNCE   = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int CODE_W     = (N_ROWS * N_COLS > 1) ? $clog2(N_ROWS * N_COLS) : 1
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst,
   input  logic [N_ROWS-1:0]        BTNY,
   output logic [N_COLS-1:0]        BTNX,
   output logic [N_ROWS*N_COLS-1:0] btns,
   output logic                     evt_valid,
   input  logic                     evt_ready,
   output logic [CODE_W-1:0]        evt_code,
   output logic                     evt_press,
   output logic                     overflow
);

   localparam int N_KEYS   = N_ROWS * N_COLS;
   localparam int DIV_W    = $clog2(SCAN_DIV);
   localparam int COL_W    = (N_COLS > 1) ? $clog2(N_COLS) : 1;
   localparam int ROW_W    = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
   localparam int CNT_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int CNT_BITS = PTR_W + 1;

`ifdef MAT_KEY_RELEASE_EVT_EN
   localparam bit REL_EN = 1'b1;
   localparam int EVT_W  = CODE_W + 1;
`else
   localparam bit REL_EN = 1'b0;
   localparam int EVT_W  = CODE_W;
`endif

   // scan state
   logic [DIV_W-1:0]  div_cnt_reg;
   logic [COL_W-1:0]  col_reg;
   logic [N_COLS-1:0] btnx_reg;
   logic [N_ROWS-1:0] samp_reg;
   logic [COL_W-1:0]  samp_col_reg;
   logic              samp_vld_reg;

   // key processing
   logic                    last_div;
   logic                    proc_en;
   logic [ROW_W-1:0]        row_idx;
   logic [CODE_W-1:0]       key_idx;
   logic                    raw;
   logic                    cur_level;
   logic [CNT_W-1:0]        cur_cnt;
   logic [CNT_W-1:0]        cnt_next;
   logic                    level_flip;
   logic                    evt_push;
   logic [N_KEYS*CNT_W-1:0] cnt_flat;
   logic [N_KEYS-1:0]       btns_level;

   // event FIFO
   logic [EVT_W-1:0]    fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_reg;
   logic [PTR_W-1:0]    rd_ptr_reg;
   logic [CNT_BITS-1:0] count_reg;
   logic [EVT_W-1:0]    head_reg;
   logic                overflow_reg;
   logic                pop;
   logic                full;
   logic                push_ok;
   logic                drop;
   logic [PTR_W-1:0]    rd_next;
   logic [CNT_BITS-1:0] count_pop;
   logic [CNT_BITS-1:0] count_next;
   logic [EVT_W-1:0]    push_data;
   logic [EVT_W-1:0]    head_next;

   always_comb begin
      last_div   = (div_cnt_reg == DIV_W'(SCAN_DIV - 1));
      row_idx    = div_cnt_reg[ROW_W-1:0];
      proc_en    = samp_vld_reg && (div_cnt_reg < DIV_W'(N_ROWS));
      key_idx    = CODE_W'(row_idx) * CODE_W'(N_COLS) + CODE_W'(samp_col_reg);
      raw        = samp_reg[row_idx];
      cur_level  = btns_level[key_idx];
      cur_cnt    = cnt_flat[key_idx*CNT_W +: CNT_W];
      cnt_next   = '0;
      level_flip = 1'b0;
      evt_push   = 1'b0;
      if (proc_en && (raw != cur_level)) begin
         if (cur_cnt == CNT_W'(DEBOUNCE - 1)) begin
            level_flip = 1'b1;
            evt_push   = REL_EN || raw;
         end else begin
            cnt_next = cur_cnt + CNT_W'(1);
         end
      end
   end

   // One debounce counter and level bit per key; only the key under the scan pointer moves.
   genvar gi;
   generate
      for (gi = 0; gi < N_KEYS; gi++) begin : g_key
         logic [CNT_W-1:0] cnt_reg;
         logic             level_reg;
         logic             hit;

         assign hit = proc_en && (key_idx == CODE_W'(gi));

         always_ff @(posedge sys_clk) begin
            if (!sys_rst) begin
               cnt_reg   <= '0;
               level_reg <= 1'b0;
            end else if (hit) begin
               cnt_reg <= cnt_next;
               if (level_flip) begin
                  level_reg <= raw;
               end
            end
         end

         assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
         assign btns_level[gi]              = level_reg;
      end
   endgenerate

   always_comb begin
      pop        = (count_reg != '0) && evt_ready;
      full       = (count_reg == CNT_BITS'(FIFO_DEPTH));
      push_ok    = evt_push && (!full || pop);
      drop       = evt_push && full && !pop;
      push_data  = EVT_W'({raw, key_idx});
      rd_next    = rd_ptr_reg + PTR_W'(pop);
      count_pop  = count_reg - CNT_BITS'(pop);
      count_next = count_pop + CNT_BITS'(push_ok);
      // A push into a FIFO that is empty after this cycle's pop becomes the new head directly.
      head_next  = (count_pop == '0) ? push_data : fifo_mem[rd_next];
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst && push_ok) begin
         fifo_mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         div_cnt_reg  <= '0;
         col_reg      <= '0;
         btnx_reg     <= '1;
         samp_reg     <= '0;
         samp_col_reg <= '0;
         samp_vld_reg <= 1'b0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         head_reg     <= '0;
         overflow_reg <= 1'b0;
      end else begin
         btnx_reg <= ~(N_COLS'(1) << col_reg);
         if (last_div) begin
            div_cnt_reg  <= '0;
            samp_reg     <= ~BTNY;
            samp_col_reg <= col_reg;
            samp_vld_reg <= 1'b1;
            col_reg      <= (col_reg == COL_W'(N_COLS - 1)) ? '0 : col_reg + COL_W'(1);
         end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
         end

         if (pop) begin
            rd_ptr_reg <= rd_next;
         end
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         count_reg <= count_next;
         if (count_next != '0) begin
            head_reg <= head_next;
         end
         if (drop) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   assign BTNX      = btnx_reg;
   assign btns      = btns_level;
   assign evt_valid = (count_reg != '0);
   assign evt_code  = head_reg[CODE_W-1:0];
   assign overflow  = overflow_reg;
`ifdef MAT_KEY_RELEASE_EVT_EN
   assign evt_press = head_reg[EVT_W-1];
`else
   assign evt_press = 1'b1;
`endif

endmodule
